// File: rtl/meta_state_rmw_ctrl.sv
// Requester-side controller for the coherence-state SRAM: zero-fills the
// array after reset, then serves single-entry read-modify-write updates
// and whole-set lookups over the wrapper's rreq/wreq/rresp interface.
module meta_state_rmw_ctrl #(
  parameter int unsigned SETS    = 128,
  parameter int unsigned WAYS    = 10,
  parameter int unsigned SUBS    = 2,
  parameter int unsigned STATE_W = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              upd_valid,
  output logic                              upd_ready,
  input  logic [$clog2(SETS)-1:0]           upd_set,
  input  logic [$clog2(WAYS)-1:0]           upd_way,
  input  logic [$clog2(SUBS)-1:0]           upd_sub,
  input  logic [STATE_W-1:0]                upd_state,
  output logic                              upd_err,
  input  logic                              rd_valid,
  output logic                              rd_ready,
  input  logic [$clog2(SETS)-1:0]           rd_set,
  output logic                              rd_resp_valid,
  output logic [WAYS*SUBS*STATE_W-1:0]      rd_resp_data,
  output logic                              init_done,
  output logic                              sram_rreq_valid,
  output logic [$clog2(SETS)-1:0]           sram_rreq_setIdx,
  input  logic [WAYS*SUBS*STATE_W-1:0]      sram_rresp_data,
  output logic                              sram_wreq_valid,
  output logic [$clog2(SETS)-1:0]           sram_wreq_setIdx,
  output logic [WAYS*SUBS*STATE_W-1:0]      sram_wreq_data,
  output logic [WAYS-1:0]                   sram_wreq_waymask
);

  localparam int unsigned SW = $clog2(SETS);
  localparam int unsigned WW = $clog2(WAYS);
  localparam int unsigned BW = $clog2(SUBS);
  localparam int unsigned DW = WAYS * SUBS * STATE_W;

  typedef enum logic [1:0] {INIT, IDLE, UPD_WR} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      cnt_q;
  logic [SW-1:0]      set_q;
  logic [WW-1:0]      way_q;
  logic [BW-1:0]      sub_q;
  logic [STATE_W-1:0] st_q;
  logic               upd_err_q;
  logic               rd_resp_valid_q;
  logic               init_done_q;
  logic               upd_fire;
  logic               rd_fire;
  logic               upd_bad;
  logic [DW-1:0]      merged;
  logic [WAYS-1:0]    way_onehot;

  assign upd_err       = upd_err_q;
  assign rd_resp_valid = rd_resp_valid_q;
  assign rd_resp_data  = sram_rresp_data;
  assign init_done     = init_done_q;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  // Sweep counter, update latches and registered status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q           <= '0;
      set_q           <= '0;
      way_q           <= '0;
      sub_q           <= '0;
      st_q            <= '0;
      upd_err_q       <= 1'b0;
      rd_resp_valid_q <= 1'b0;
      init_done_q     <= 1'b0;
    end else begin
      if (state_q == INIT) begin
        cnt_q <= cnt_q + SW'(1);
        if (cnt_q == SW'(SETS - 1)) init_done_q <= 1'b1;
      end
      if (upd_fire) begin
        set_q <= upd_set;
        way_q <= upd_way;
        sub_q <= upd_sub;
        st_q  <= upd_state;
      end
      upd_err_q       <= upd_fire && upd_bad;
      rd_resp_valid_q <= rd_fire;
    end
  end

  // Replace only the latched (way,sub) entry of the read word; one-hot way mask
  always_comb begin
    merged     = sram_rresp_data;
    way_onehot = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_q == WW'(w)) way_onehot[w] = 1'b1;
      for (int unsigned s = 0; s < SUBS; s++) begin
        if (way_q == WW'(w) && sub_q == BW'(s))
          merged[(w*SUBS+s)*STATE_W +: STATE_W] = st_q;
      end
    end
  end

  // Next-state, handshakes and SRAM requests; updates take priority over lookups
  always_comb begin
    state_d           = state_q;
    upd_ready         = 1'b0;
    rd_ready          = 1'b0;
    upd_fire          = 1'b0;
    rd_fire           = 1'b0;
    upd_bad           = 1'b0;
    sram_rreq_valid   = 1'b0;
    sram_rreq_setIdx  = '0;
    sram_wreq_valid   = 1'b0;
    sram_wreq_setIdx  = '0;
    sram_wreq_data    = '0;
    sram_wreq_waymask = '0;
    if (!reset) begin
      case (state_q)
        INIT: begin
          sram_wreq_valid   = 1'b1;
          sram_wreq_setIdx  = cnt_q;
          sram_wreq_waymask = '1;
          if (cnt_q == SW'(SETS - 1)) state_d = IDLE;
        end
        IDLE: begin
          upd_ready = 1'b1;
          rd_ready  = !upd_valid;
          if (upd_valid) begin
            upd_fire = 1'b1;
            if (upd_way >= WW'(WAYS)) begin
              upd_bad = 1'b1;
            end else begin
              sram_rreq_valid  = 1'b1;
              sram_rreq_setIdx = upd_set;
              state_d          = UPD_WR;
            end
          end else if (rd_valid) begin
            rd_fire          = 1'b1;
            sram_rreq_valid  = 1'b1;
            sram_rreq_setIdx = rd_set;
          end
        end
        UPD_WR: begin
          sram_wreq_valid   = 1'b1;
          sram_wreq_setIdx  = set_q;
          sram_wreq_data    = merged;
          sram_wreq_waymask = way_onehot;
          state_d           = IDLE;
        end
        default: state_d = INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_meta_state_rmw_ctrl.sv
// Scoreboard bench for meta_state_rmw_ctrl with a behavioural state SRAM.
module tb_meta_state_rmw_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [6:0]  upd_set = '0;
  logic [3:0]  upd_way = '0;
  logic        upd_sub = 1'b0;
  logic [1:0]  upd_state = '0;
  logic        upd_err;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [6:0]  rd_set = '0;
  logic        rd_resp_valid;
  logic [39:0] rd_resp_data;
  logic        init_done;
  logic        sram_rreq_valid;
  logic [6:0]  sram_rreq_setIdx;
  logic [39:0] sram_rresp_data = '0;
  logic        sram_wreq_valid;
  logic [6:0]  sram_wreq_setIdx;
  logic [39:0] sram_wreq_data;
  logic [9:0]  sram_wreq_waymask;

  meta_state_rmw_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .upd_valid         (upd_valid),
    .upd_ready         (upd_ready),
    .upd_set           (upd_set),
    .upd_way           (upd_way),
    .upd_sub           (upd_sub),
    .upd_state         (upd_state),
    .upd_err           (upd_err),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .rd_set            (rd_set),
    .rd_resp_valid     (rd_resp_valid),
    .rd_resp_data      (rd_resp_data),
    .init_done         (init_done),
    .sram_rreq_valid   (sram_rreq_valid),
    .sram_rreq_setIdx  (sram_rreq_setIdx),
    .sram_rresp_data   (sram_rresp_data),
    .sram_wreq_valid   (sram_wreq_valid),
    .sram_wreq_setIdx  (sram_wreq_setIdx),
    .sram_wreq_data    (sram_wreq_data),
    .sram_wreq_waymask (sram_wreq_waymask)
  );

  always #5 clock = ~clock;

  // Expected write: {set[6:0], waymask[9:0], data[39:0]}
  typedef logic [56:0] wr_t;
  wr_t         exp_wr[$];
  logic [39:0] exp_rd[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_rreq = 0;
  int          n_err_seen = 0;

  // Behavioural SRAM: write wins, read data one cycle after the request
  logic [39:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = {5{8'hA5}};
  always @(posedge clock) begin
    if (sram_wreq_valid) begin
      for (int w = 0; w < 10; w++)
        if (sram_wreq_waymask[w]) mem[sram_wreq_setIdx][w*4 +: 4] <= sram_wreq_data[w*4 +: 4];
    end else if (sram_rreq_valid) begin
      sram_rresp_data <= mem[sram_rreq_setIdx];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected writes and lookup responses as the DUT presents them
  wr_t         mon_e;
  logic [39:0] mon_d;
  always @(negedge clock) begin
    if (sram_rreq_valid) n_rreq++;
    if (upd_err) n_err_seen++;
    if (sram_rreq_valid && sram_wreq_valid) begin
      n_checks++; n_errors++;
      $display("FAIL rw_overlap: read and write requested together at %0t", $time);
    end
    if (sram_wreq_valid) begin
      if (exp_wr.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_write: set %0d mask %h data %h at %0t",
                 sram_wreq_setIdx, sram_wreq_waymask, sram_wreq_data, $time);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_set",  64'(sram_wreq_setIdx),  64'(mon_e[56:50]));
        chk("wr_mask", 64'(sram_wreq_waymask), 64'(mon_e[49:40]));
        chk("wr_data", 64'(sram_wreq_data),    64'(mon_e[39:0]));
      end
    end
    if (rd_resp_valid) begin
      if (exp_rd.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_resp: data %h at %0t", rd_resp_data, $time);
      end else begin
        mon_d = exp_rd.pop_front();
        chk("rd_resp_data", 64'(rd_resp_data), 64'(mon_d));
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; upd_valid = 1'b0; rd_valid = 1'b0;
    exp_wr.delete(); exp_rd.delete();
    #1;
    chk("rst_upd_ready", 64'(upd_ready), 64'd0);
    chk("rst_rd_ready",  64'(rd_ready),  64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_sram_wreq", 64'(sram_wreq_valid), 64'd0);
    chk("rst_sram_rreq", 64'(sram_rreq_valid), 64'd0);
    chk("rst_resp_err",  64'({rd_resp_valid, upd_err}), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 128; i++) exp_wr.push_back({7'(i), 10'h3FF, 40'h0});
  endtask

  task automatic wait_init();
    repeat (127) tick();
    chk("init_done_127", 64'(init_done), 64'd0);
    tick();
    chk("init_done_128", 64'(init_done), 64'd1);
  endtask

  // Presents one update for a single accept cycle; caller ticks through UPD_WR
  task automatic do_update(input logic [6:0] s, input logic [3:0] w, input logic sb,
                           input logic [1:0] st, input logic [39:0] exp_d,
                           input logic [9:0] exp_m, input bit expect_wr);
    upd_valid = 1'b1; upd_set = s; upd_way = w; upd_sub = sb; upd_state = st;
    if (expect_wr) exp_wr.push_back({s, exp_m, exp_d});
    @(negedge clock);
    chk("upd_ready", 64'(upd_ready), 64'd1);
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [6:0] s, input logic [39:0] exp);
    int n;
    n = 0;
    rd_valid = 1'b1; rd_set = s;
    exp_rd.push_back(exp);
    @(negedge clock);
    while (!rd_ready && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (!rd_ready) begin
      n_checks++; n_errors++;
      $display("FAIL lookup_timeout: rd_ready stayed 0 for set %0d", s);
      void'(exp_rd.pop_back());
    end
    tick();
    rd_valid = 1'b0;
  endtask

  initial begin
    int rq0;
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rq0;
    do_reset();
    chk("sweep_first_set", 64'(sram_wreq_setIdx), 64'd0);
    wait_init();
    chk("sweep_all_written", 64'(exp_wr.size()), 64'd0);

    do_lookup(7'd5, 40'h0);

    do_update(7'd3, 4'd7, 1'b1, 2'b10, 40'h00_8000_0000, 10'h080, 1'b1);
    tick();
    do_lookup(7'd3, 40'h00_8000_0000);

    do_update(7'd3, 4'd7, 1'b0, 2'b01, 40'h00_9000_0000, 10'h080, 1'b1);
    tick();
    do_lookup(7'd3, 40'h00_9000_0000);

    // Update and lookup presented together: update first, lookup two cycles later
    upd_valid = 1'b1; upd_set = 7'd3; upd_way = 4'd2; upd_sub = 1'b0; upd_state = 2'b11;
    rd_valid = 1'b1; rd_set = 7'd3;
    exp_wr.push_back({7'd3, 10'h004, 40'h00_9000_0300});
    exp_rd.push_back(40'h00_9000_0300);
    @(negedge clock);
    chk("prio_rd_ready_0", 64'(rd_ready), 64'd0);
    chk("prio_upd_ready",  64'(upd_ready), 64'd1);
    tick();
    upd_valid = 1'b0;
    @(negedge clock);
    chk("prio_rd_ready_updwr", 64'(rd_ready), 64'd0);
    tick();
    @(negedge clock);
    chk("prio_rd_ready_1", 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 1'b0;

    // Out-of-range way: error pulse, no SRAM traffic
    rq0 = n_rreq;
    upd_valid = 1'b1; upd_set = 7'd3; upd_way = 4'd12; upd_sub = 1'b0; upd_state = 2'b11;
    tick();
    upd_valid = 1'b0;
    @(negedge clock);
    chk("upd_err_pulse", 64'(upd_err), 64'd1);
    tick();
    @(negedge clock);
    chk("upd_err_clear", 64'(upd_err), 64'd0);
    chk("err_no_rreq", 64'(n_rreq - rq0), 64'd0);
    tick();
    do_lookup(7'd3, 40'h00_9000_0300);

    // Highest way/sub on the last set, then back-to-back lookups
    do_update(7'd127, 4'd9, 1'b1, 2'b01, 40'h40_0000_0000, 10'h200, 1'b1);
    tick();
    do_lookup(7'd127, 40'h40_0000_0000);
    do_lookup(7'd3,   40'h00_9000_0300);
    do_lookup(7'd5,   40'h0);
    repeat (2) tick();
    chk("pre_reset_queues", 64'(exp_wr.size() + exp_rd.size()), 64'd0);

    // Reset during UPD_WR: merge write must never appear
    do_update(7'd9, 4'd1, 1'b0, 2'b11, 40'h0, 10'h0, 1'b0);
    do_reset();
    repeat (60) tick();
    chk("sweep_at_60", 64'(sram_wreq_setIdx), 64'd60);
    do_reset();
    chk("sweep_restart_0", 64'(sram_wreq_setIdx), 64'd0);
    wait_init();

    do_lookup(7'd9,   40'h0);
    do_lookup(7'd3,   40'h0);
    do_lookup(7'd127, 40'h0);
    repeat (3) tick();

    chk("final_wr_queue", 64'(exp_wr.size()), 64'd0);
    chk("final_rd_queue", 64'(exp_rd.size()), 64'd0);
    chk("upd_err_count",  64'(n_err_seen),    64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
